pyrm_reg_file_block: RTL and testbench
======================================

// Module: pyrm_reg_file_block
// PURPOSE
// - Integer register file directly downstream of write-back.
// - Consumes the decode_reg_addr / decode_reg_data result pair produced by write-back.
// - Serves two combinational source-operand reads to decode.
// - Keeps a per-register busy scoreboard so decode stalls on RAW and WAW hazards until write-back retires.
// PARAMETERS
// - NREGS  32  architectural registers; index width = $clog2(NREGS).
// - XLEN   64  register and data width.
// PORTS
// - clk                     in   1     clock; all state updates on rising edge.
// - reset_pyri              in   1     synchronous, active-low reset (0 = reset).
// - wb_reg_addr_pyri        in   64    destination register from write-back; only [4:0] used.
// - wb_reg_addr_valid_pyri  in   1     address valid.
// - wb_reg_addr_retry_pyro  out  1     address not accepted this cycle.
// - wb_reg_data_pyri        in   64    result data from write-back.
// - wb_reg_data_valid_pyri  in   1     data valid.
// - wb_reg_data_retry_pyro  out  1     data not accepted this cycle.
// - rs1_addr_pyri           in   5     decode read port 1 index.
// - rs2_addr_pyri           in   5     decode read port 2 index.
// - rs1_data_pyro           out  64    read port 1 value.
// - rs2_data_pyro           out  64    read port 2 value.
// - rs1_busy_pyro           out  1     rs1 has a write outstanding.
// - rs2_busy_pyro           out  1     rs2 has a write outstanding.
// - issue_rd_pyri           in   5     rd of the instruction decode is issuing.
// - issue_valid_pyri        in   1     issue request; rd=0 means no destination.
// - issue_retry_pyro        out  1     issue refused (WAW); decode holds the request.
// BEHAVIOUR
// - Handshake: a channel transfers on a cycle with valid=1 and retry=0.
// - Pairing latch:
//   - Addr and data may arrive in different cycles. A lone transfer is held in a 1-entry latch for that channel until its partner arrives.
//   - A channel's retry=1 while its latch is full and the partner has not yet arrived. Otherwise retry=0.
//   - A commit occurs in the cycle both halves are available (latched or transferring).
//   - On commit the register is written, both latches clear, and busy[rd] clears at the clock edge.
//   - Same-cycle arrival of both halves commits with zero latency.
// - x0: writes to index 0 are dropped, though the transfer still completes. Reads of index 0 return 0; busy[0] is always 0.
// - Reads: rsN_data = regs[rsN] combinationally; rsN_busy = busy[rsN].
// - Scoreboard (NREGS-bit busy vector):
//   - issue_retry_pyro = issue_valid && rd!=0 && busy[rd] && !(commit to rd this cycle).
//   - An accepted issue with rd!=0 sets busy[rd].
//   - Commit and issue to the same rd in one cycle: the set wins, so busy stays 1 for the new producer.
//   - Commit to rd with busy[rd]=0 writes data; busy is unchanged (no underflow).
// - Reset (reset_pyri=0 at the edge):
//   - All regs become 0, busy becomes 0, both latches empty.
//   - Retries are 0; read outputs are 0 for all indices.
//   - Reset mid-pairing discards the half-pair.
// CONFIGURATION
// - PYRM_REGFILE_BYPASS_EN defined:
//   - A read of the index being committed this cycle returns the commit data, with busy=0 (unless a same-cycle issue re-sets it, which is visible next cycle).
//   - issue_retry is as above.
// - Not defined:
//   - Reads return the pre-commit value and busy=1 during the commit cycle; the new value is visible the next cycle.
// TESTING
// - Reset: hold reset_pyri=0 for 2 cycles, then read x1..x31 -> all 0, busy 0, all retries 0.
// - Paired write: addr=5, data=64'hDEAD_BEEF_0000_0001 valid same cycle -> next cycle rs1=5 reads that value.
// - Split write, addr first:
//   - addr=7 at cycle 0, second addr=8 at cycle 1 -> addr retry=1 at cycle 1.
//   - data=64'h42 at cycle 2 -> x7=64'h42 at cycle 3; x8 is accepted after.
// - x0: issue rd=0, then write addr=0 data=64'hFF -> no retry, x0 reads 0, busy[0]=0.
// - Scoreboard:
//   - Issue rd=3 -> busy[3]=1; second issue rd=3 -> retry=1.
//   - Commit x3 -> retry drops the same cycle and the issue is accepted; busy[3] stays 1.
// - Bypass: commit x9=64'h1234 while rs2=9:
//   - With PYRM_REGFILE_BYPASS_EN -> rs2 reads 64'h1234 and busy=0 that cycle.
//   - Without -> rs2 reads the old value that cycle and 64'h1234 the next cycle.

Source files
------------

// File: rtl/pyrm_reg_file_block.sv
// pyrm_reg_file_block: integer register file fed by write-back.
// Write-back sends the destination address and the result data on two
// independent valid/retry channels. They are paired through one-entry
// latches, and the register is written once both halves are present.
// Two combinational read ports serve decode. A busy scoreboard marks
// destinations that still have a write outstanding.
// Optional feature: define PYRM_REGFILE_BYPASS_EN to forward the value
// being committed to a same-cycle read of that register.
module pyrm_reg_file_block #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_pyri,
  input  logic [63:0]      wb_reg_addr_pyri,
  input  logic             wb_reg_addr_valid_pyri,
  output logic             wb_reg_addr_retry_pyro,
  input  logic [XLEN-1:0]  wb_reg_data_pyri,
  input  logic             wb_reg_data_valid_pyri,
  output logic             wb_reg_data_retry_pyro,
  input  logic [IDXW-1:0]  rs1_addr_pyri,
  input  logic [IDXW-1:0]  rs2_addr_pyri,
  output logic [XLEN-1:0]  rs1_data_pyro,
  output logic [XLEN-1:0]  rs2_data_pyro,
  output logic             rs1_busy_pyro,
  output logic             rs2_busy_pyro,
  input  logic [IDXW-1:0]  issue_rd_pyri,
  input  logic             issue_valid_pyri,
  output logic             issue_retry_pyro
);

  // Only the low index bits of the write-back address select a register.
  logic unused_addr_bits;
  assign unused_addr_bits = ^wb_reg_addr_pyri[63:IDXW];

  logic [XLEN-1:0] regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  logic [IDXW-1:0] addr_latch_reg;
  logic            addr_full_reg;
  logic [XLEN-1:0] data_latch_reg;
  logic            data_full_reg;

  logic            addr_xfer;
  logic            data_xfer;
  logic            commit;
  logic            commit_wr;
  logic [IDXW-1:0] commit_idx;
  logic [XLEN-1:0] commit_data;
  logic            issue_set;

  // Handshake, pairing and scoreboard decisions for the current cycle.
  always_comb begin
    // A channel stalls only when it already holds a half and its partner
    // is neither latched nor arriving now.
    wb_reg_addr_retry_pyro = reset_pyri && addr_full_reg &&
                             !data_full_reg && !wb_reg_data_valid_pyri;
    wb_reg_data_retry_pyro = reset_pyri && data_full_reg &&
                             !addr_full_reg && !wb_reg_addr_valid_pyri;
    addr_xfer = wb_reg_addr_valid_pyri && !wb_reg_addr_retry_pyro;
    data_xfer = wb_reg_data_valid_pyri && !wb_reg_data_retry_pyro;

    commit      = (addr_full_reg || addr_xfer) && (data_full_reg || data_xfer);
    commit_idx  = addr_full_reg ? addr_latch_reg : wb_reg_addr_pyri[IDXW-1:0];
    commit_data = data_full_reg ? data_latch_reg : wb_reg_data_pyri;
    commit_wr   = commit && (commit_idx != '0);

    // A retiring write to the same rd releases the WAW stall in-cycle.
    issue_retry_pyro = reset_pyri && issue_valid_pyri && (issue_rd_pyri != '0) &&
                       busy_reg[issue_rd_pyri] &&
                       !(commit && (commit_idx == issue_rd_pyri));
    issue_set = issue_valid_pyri && !issue_retry_pyro && (issue_rd_pyri != '0);

    // Clear on retire first so that a same-cycle issue re-marks the register.
    busy_next = busy_reg;
    if (commit) busy_next[commit_idx] = 1'b0;
    if (issue_set) busy_next[issue_rd_pyri] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Pairing latches: a lone half waits; a half left over after a commit
  // (new arrival while the old one was consumed) is kept for the next pair.
  always_ff @(posedge clk) begin
    if (!reset_pyri) begin
      addr_full_reg  <= 1'b0;
      data_full_reg  <= 1'b0;
      addr_latch_reg <= '0;
      data_latch_reg <= '0;
    end else begin
      if (addr_xfer) addr_latch_reg <= wb_reg_addr_pyri[IDXW-1:0];
      if (data_xfer) data_latch_reg <= wb_reg_data_pyri;
      addr_full_reg <= commit ? (addr_full_reg && addr_xfer) : (addr_full_reg || addr_xfer);
      data_full_reg <= commit ? (data_full_reg && data_xfer) : (data_full_reg || data_xfer);
    end
  end

  // Register array and busy vector; x0 is never written so it reads as 0.
  always_ff @(posedge clk) begin
    if (!reset_pyri) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
      busy_reg <= '0;
    end else begin
      if (commit_wr) regs_reg[commit_idx] <= commit_data;
      busy_reg <= busy_next;
    end
  end

  logic [IDXW-1:0] rs_addr [2];
  logic [XLEN-1:0] rs_data [2];
  logic            rs_busy [2];

  assign rs_addr[0]    = rs1_addr_pyri;
  assign rs_addr[1]    = rs2_addr_pyri;
  assign rs1_data_pyro = rs_data[0];
  assign rs2_data_pyro = rs_data[1];
  assign rs1_busy_pyro = rs_busy[0];
  assign rs2_busy_pyro = rs_busy[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      // Combinational read port, optionally forwarding the retiring write.
      always_comb begin
        rs_data[gi] = regs_reg[rs_addr[gi]];
        rs_busy[gi] = busy_reg[rs_addr[gi]];
`ifdef PYRM_REGFILE_BYPASS_EN
        if (commit_wr && (commit_idx == rs_addr[gi])) begin
          rs_data[gi] = commit_data;
          rs_busy[gi] = 1'b0;
        end
`endif
        if (!reset_pyri) begin
          rs_data[gi] = '0;
          rs_busy[gi] = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pyrm_reg_file_block.sv
// Scoreboard bench for pyrm_reg_file_block: stimulus pushes expected
// output values tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them.
module tb_pyrm_reg_file_block;

  localparam int K_RS1D = 0, K_RS2D = 1, K_RS1B = 2, K_RS2B = 3;
  localparam int K_ART = 4, K_DRT = 5, K_IRT = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_pyri;
  logic [63:0] wb_reg_addr_pyri;
  logic        wb_reg_addr_valid_pyri;
  logic        wb_reg_addr_retry_pyro;
  logic [63:0] wb_reg_data_pyri;
  logic        wb_reg_data_valid_pyri;
  logic        wb_reg_data_retry_pyro;
  logic [4:0]  rs1_addr_pyri;
  logic [4:0]  rs2_addr_pyri;
  logic [63:0] rs1_data_pyro;
  logic [63:0] rs2_data_pyro;
  logic        rs1_busy_pyro;
  logic        rs2_busy_pyro;
  logic [4:0]  issue_rd_pyri;
  logic        issue_valid_pyri;
  logic        issue_retry_pyro;

  exp_t exp_q[$];
  int   cycle_no = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  pyrm_reg_file_block dut (
    .clk                    (clk),
    .reset_pyri             (reset_pyri),
    .wb_reg_addr_pyri       (wb_reg_addr_pyri),
    .wb_reg_addr_valid_pyri (wb_reg_addr_valid_pyri),
    .wb_reg_addr_retry_pyro (wb_reg_addr_retry_pyro),
    .wb_reg_data_pyri       (wb_reg_data_pyri),
    .wb_reg_data_valid_pyri (wb_reg_data_valid_pyri),
    .wb_reg_data_retry_pyro (wb_reg_data_retry_pyro),
    .rs1_addr_pyri          (rs1_addr_pyri),
    .rs2_addr_pyri          (rs2_addr_pyri),
    .rs1_data_pyro          (rs1_data_pyro),
    .rs2_data_pyro          (rs2_data_pyro),
    .rs1_busy_pyro          (rs1_busy_pyro),
    .rs2_busy_pyro          (rs2_busy_pyro),
    .issue_rd_pyri          (issue_rd_pyri),
    .issue_valid_pyri       (issue_valid_pyri),
    .issue_retry_pyro       (issue_retry_pyro)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Monitor: compare every expectation due this cycle against the outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_no) begin
      exp_t        e;
      logic [63:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_RS1D:  act = rs1_data_pyro;
        K_RS2D:  act = rs2_data_pyro;
        K_RS1B:  act = {63'd0, rs1_busy_pyro};
        K_RS2B:  act = {63'd0, rs2_busy_pyro};
        K_ART:   act = {63'd0, wb_reg_addr_retry_pyro};
        K_DRT:   act = {63'd0, wb_reg_data_retry_pyro};
        default: act = {63'd0, issue_retry_pyro};
      endcase
      n_checks++;
      if (e.cyc != cycle_no || act !== e.val) begin
        n_fails++;
        $display("FAIL %s cyc=%0d: got %h expected %h", e.name, cycle_no, act, e.val);
      end else begin
        $display("ok   %s cyc=%0d: %h", e.name, cycle_no, act);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [63:0] val, input string name);
    exp_t e;
    e.cyc  = cycle_no;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and return all request inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    wb_reg_addr_valid_pyri = 1'b0;
    wb_reg_data_valid_pyri = 1'b0;
    issue_valid_pyri       = 1'b0;
    wb_reg_addr_pyri       = '0;
    wb_reg_data_pyri       = '0;
    issue_rd_pyri          = '0;
    rs1_addr_pyri          = '0;
    rs2_addr_pyri          = '0;
  endtask

  task automatic send_addr(input logic [63:0] a);
    wb_reg_addr_valid_pyri = 1'b1;
    wb_reg_addr_pyri       = a;
  endtask

  task automatic send_data(input logic [63:0] d);
    wb_reg_data_valid_pyri = 1'b1;
    wb_reg_data_pyri       = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid_pyri = 1'b1;
    issue_rd_pyri    = rd;
  endtask

  initial begin
    reset_pyri             = 1'b0;
    wb_reg_addr_valid_pyri = 1'b0;
    wb_reg_data_valid_pyri = 1'b0;
    issue_valid_pyri       = 1'b0;
    wb_reg_addr_pyri       = '0;
    wb_reg_data_pyri       = '0;
    issue_rd_pyri          = '0;
    rs1_addr_pyri          = '0;
    rs2_addr_pyri          = '0;
    cyc(); cyc();
    reset_pyri = 1'b1;

    // Populate state, leave an address half-pair latched, then reset.
    cyc(); send_addr(64'd1); send_data(64'h55);
    cyc(); send_addr(64'd2); send_data(64'h66);
    cyc(); send_addr(64'd11);
    cyc(); reset_pyri = 1'b0;
    cyc(); reset_pyri = 1'b0;
    cyc(); reset_pyri = 1'b1;

    // Everything reads back clear after reset.
    for (int i = 1; i < 32; i++) begin
      rs1_addr_pyri = 5'(i);
      rs2_addr_pyri = 5'(i);
      expect_val(K_RS1D, 64'd0, "reset_rs1_data");
      expect_val(K_RS1B, 64'd0, "reset_rs1_busy");
      expect_val(K_RS2B, 64'd0, "reset_rs2_busy");
      if (i == 1) begin
        expect_val(K_ART, 64'd0, "reset_addr_retry");
        expect_val(K_DRT, 64'd0, "reset_data_retry");
        expect_val(K_IRT, 64'd0, "reset_issue_retry");
      end
      if (i < 31) cyc();
    end

    // Discarded half-pair: a lone data must not commit to x11.
    cyc(); send_data(64'h77);
    expect_val(K_DRT, 64'd0, "lone_data_retry");
    cyc(); send_data(64'h88); rs1_addr_pyri = 5'd11; rs2_addr_pyri = 5'd10;
    expect_val(K_DRT, 64'd1, "data_latch_full_retry");
    expect_val(K_RS1D, 64'd0, "halfpair_discarded_x11");
    expect_val(K_RS2D, 64'd0, "x10_before_commit");
    cyc(); send_data(64'h88); send_addr(64'd10);
    expect_val(K_DRT, 64'd0, "data_retry_partner_arrives");
    expect_val(K_ART, 64'd0, "addr_retry_partner_latched");
    cyc(); rs2_addr_pyri = 5'd10; send_addr(64'd12);
    expect_val(K_RS2D, 64'h77, "x10_commit");
    cyc(); rs1_addr_pyri = 5'd12;
    expect_val(K_RS1D, 64'h88, "x12_leftover_data_commit");

    // Paired write with zero latency.
    cyc(); send_addr(64'd5); send_data(64'hDEAD_BEEF_0000_0001);
    cyc(); rs1_addr_pyri = 5'd5;
    expect_val(K_RS1D, 64'hDEAD_BEEF_0000_0001, "paired_x5");
    expect_val(K_RS1B, 64'd0, "paired_x5_busy");

    // Split write, address first, second address stalls.
    cyc(); send_addr(64'd7);
    expect_val(K_ART, 64'd0, "split_addr7_retry");
    cyc(); send_addr(64'd8);
    expect_val(K_ART, 64'd1, "split_addr8_retry");
    cyc(); send_addr(64'd8); send_data(64'h42);
    expect_val(K_ART, 64'd0, "split_addr8_accept");
    expect_val(K_DRT, 64'd0, "split_data_accept");
    cyc(); rs1_addr_pyri = 5'd7; send_data(64'h99);
    expect_val(K_RS1D, 64'h42, "split_x7");
    cyc(); rs2_addr_pyri = 5'd8;
    expect_val(K_RS2D, 64'h99, "split_x8");

    // x0 is never busy and never written.
    cyc(); issue(5'd0); rs1_addr_pyri = 5'd0;
    expect_val(K_IRT, 64'd0, "x0_issue_retry");
    expect_val(K_RS1B, 64'd0, "x0_busy_after_issue");
    cyc(); send_addr(64'd0); send_data(64'hFF);
    expect_val(K_ART, 64'd0, "x0_addr_retry");
    expect_val(K_DRT, 64'd0, "x0_data_retry");
    cyc(); rs1_addr_pyri = 5'd0;
    expect_val(K_RS1D, 64'd0, "x0_data");
    expect_val(K_RS1B, 64'd0, "x0_busy");

    // Scoreboard WAW stall and same-cycle commit release.
    cyc(); issue(5'd3);
    expect_val(K_IRT, 64'd0, "issue_x3_first");
    cyc(); issue(5'd3); rs1_addr_pyri = 5'd3;
    expect_val(K_RS1B, 64'd1, "x3_busy");
    expect_val(K_IRT, 64'd1, "issue_x3_waw");
    cyc(); issue(5'd3); send_addr(64'd3); send_data(64'h333); rs1_addr_pyri = 5'd3;
    expect_val(K_IRT, 64'd0, "issue_x3_released");
`ifdef PYRM_REGFILE_BYPASS_EN
    expect_val(K_RS1D, 64'h333, "x3_commit_cycle_data");
    expect_val(K_RS1B, 64'd0, "x3_commit_cycle_busy");
`else
    expect_val(K_RS1D, 64'd0, "x3_commit_cycle_data");
    expect_val(K_RS1B, 64'd1, "x3_commit_cycle_busy");
`endif
    cyc(); issue(5'd3); rs1_addr_pyri = 5'd3;
    expect_val(K_RS1D, 64'h333, "x3_after_commit");
    expect_val(K_RS1B, 64'd1, "x3_busy_set_wins");
    expect_val(K_IRT, 64'd1, "issue_x3_waw_again");
    cyc(); send_addr(64'd3); send_data(64'h334);
    cyc(); rs1_addr_pyri = 5'd3;
    expect_val(K_RS1D, 64'h334, "x3_second_commit");
    expect_val(K_RS1B, 64'd0, "x3_busy_cleared");

    // Commit-cycle read of x9 on port 2.
    cyc(); send_addr(64'd9); send_data(64'h1111);
    cyc(); issue(5'd9);
    expect_val(K_IRT, 64'd0, "issue_x9");
    cyc(); send_addr(64'd9); send_data(64'h1234); rs2_addr_pyri = 5'd9;
`ifdef PYRM_REGFILE_BYPASS_EN
    expect_val(K_RS2D, 64'h1234, "bypass_x9_data");
    expect_val(K_RS2B, 64'd0, "bypass_x9_busy");
`else
    expect_val(K_RS2D, 64'h1111, "nobypass_x9_old");
    expect_val(K_RS2B, 64'd1, "nobypass_x9_busy");
`endif
    cyc(); rs2_addr_pyri = 5'd9;
    expect_val(K_RS2D, 64'h1234, "x9_next_cycle");
    expect_val(K_RS2B, 64'd0, "x9_busy_next_cycle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) cyc();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
